// File: rtl/dtw_diag_feeder_pkg.sv
// dtw_diag_feeder_pkg: shared sizes, round constants and FSM encoding for the DTW diagonal feeder.
package dtw_diag_feeder_pkg;
  localparam int LANES = 6;
  localparam int SAMPLE_W = 10;
  localparam int SMP_W = 3 * SAMPLE_W;
  localparam int SEQ_LEN = 20;
  localparam int ADDR_W = 5;
  localparam int ROUND_W = 6;
  localparam logic [ROUND_W-1:0] IDLE_ROUND = 6'd63;
  localparam logic [ROUND_W-1:0] LAST_ROUND = 6'(2 * SEQ_LEN - 1);
  typedef enum logic [1:0] {S_IDLE, S_CLR, S_ISSUE, S_DRAIN} state_e;
endpackage

// File: rtl/dtw_lane_index.sv
// dtw_lane_index: maps (round, lane) onto matrix cell (i, j) and flags whether it lies inside the matrix.
module dtw_lane_index
  import dtw_diag_feeder_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [ROUND_W-1:0] round_i,
  output logic [ADDR_W-1:0]  i_o,
  output logic [ADDR_W-1:0]  j_o,
  output logic               legal_o
);
  logic signed [6:0] d, s, t, i, j;
  assign d = 7'(2 * LANE - 4) - {6'd0, round_i[0]};
  assign s = {1'b0, round_i} + d;
  assign t = {1'b0, round_i} - d;
  assign i = s >>> 1;
  assign j = t >>> 1;
  // Indices are zeroed when out of range so the memory read never leaves the array.
  assign legal_o = ~s[0] & ~i[6] & ~j[6] & (i < 7'(SEQ_LEN)) & (j < 7'(SEQ_LEN)) & (round_i < LAST_ROUND);
  assign i_o = legal_o ? i[ADDR_W-1:0] : '0;
  assign j_o = legal_o ? j[ADDR_W-1:0] : '0;
endmodule

// File: rtl/dtw_diag_feeder.sv
// dtw_diag_feeder: stores sequences A and B and issues one anti-diagonal of cells per acknowledged round.
module dtw_diag_feeder
  import dtw_diag_feeder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SMP_W-1:0]    wr_data,
  input  logic                start,
  input  logic                adv_i,
  input  logic                finish_i,
  output logic                clr_o,
  output logic                valid,
  output logic [ROUND_W-1:0]  data_number,
  output logic [SAMPLE_W-1:0] a1_o_0, a2_o_0, a3_o_0, b1_o_0, b2_o_0, b3_o_0,
  output logic [SAMPLE_W-1:0] a1_o_1, a2_o_1, a3_o_1, b1_o_1, b2_o_1, b3_o_1,
  output logic [SAMPLE_W-1:0] a1_o_2, a2_o_2, a3_o_2, b1_o_2, b2_o_2, b3_o_2,
  output logic [SAMPLE_W-1:0] a1_o_3, a2_o_3, a3_o_3, b1_o_3, b2_o_3, b3_o_3,
  output logic [SAMPLE_W-1:0] a1_o_4, a2_o_4, a3_o_4, b1_o_4, b2_o_4, b3_o_4,
  output logic [SAMPLE_W-1:0] a1_o_5, a2_o_5, a3_o_5, b1_o_5, b2_o_5, b3_o_5,
  output logic                legal_o_0, legal_o_1, legal_o_2, legal_o_3, legal_o_4, legal_o_5,
  output logic                busy,
  output logic                done
);
  state_e state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d, nr;
  logic valid_q, valid_d, done_q, done_d, load;
  logic [SMP_W-1:0] mem_a [SEQ_LEN];
  logic [SMP_W-1:0] mem_b [SEQ_LEN];
  logic [ADDR_W-1:0] li [LANES];
  logic [ADDR_W-1:0] lj [LANES];
  logic [LANES-1:0] lg, legal_q;
  logic [SMP_W-1:0] a_d [LANES];
  logic [SMP_W-1:0] b_d [LANES];
  logic [LANES-1:0][SMP_W-1:0] a_q, b_q;
  // Memories are deliberately outside reset so a reset mid-run keeps loaded data.
  always_ff @(posedge clk)
    if (state_q == S_IDLE && wr_en && wr_addr < 5'(SEQ_LEN)) begin
      if (wr_sel) mem_b[wr_addr] <= wr_data;
      else mem_a[wr_addr] <= wr_data;
    end
  assign nr = (state_q == S_CLR) ? '0 : round_q + 1'b1;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dtw_lane_index #(.LANE(l)) u_idx (
      .round_i(nr),
      .i_o    (li[l]),
      .j_o    (lj[l]),
      .legal_o(lg[l])
    );
    assign a_d[l] = lg[l] ? mem_a[li[l]] : '0;
    assign b_d[l] = lg[l] ? mem_b[lj[l]] : '0;
  end
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d = 1'b0;
    load = 1'b0;
    case (state_q)
      S_IDLE: state_d = start ? S_CLR : S_IDLE;
      S_CLR: begin
        state_d = S_ISSUE;
        round_d = nr;
        valid_d = 1'b1;
        load = 1'b1;
      end
      S_ISSUE:
        if (adv_i) begin
          if (round_q == LAST_ROUND) state_d = S_DRAIN;
          else begin
            round_d = nr;
            load = 1'b1;
          end
        end
      S_DRAIN:
        if (finish_i) begin
          state_d = S_IDLE;
          done_d = 1'b1;
          valid_d = 1'b0;
          round_d = IDLE_ROUND;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      round_q <= IDLE_ROUND;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      legal_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      valid_q <= valid_d;
      done_q <= done_d;
      if (load) begin
        legal_q <= lg;
        for (int k = 0; k < LANES; k++) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
        end
      end
    end
  assign clr_o = state_q == S_CLR;
  assign busy = state_q != S_IDLE;
  assign valid = valid_q;
  assign done = done_q;
  assign data_number = round_q;
  assign {legal_o_5, legal_o_4, legal_o_3, legal_o_2, legal_o_1, legal_o_0} = legal_q;
  assign {a3_o_0, a2_o_0, a1_o_0} = a_q[0];
  assign {a3_o_1, a2_o_1, a1_o_1} = a_q[1];
  assign {a3_o_2, a2_o_2, a1_o_2} = a_q[2];
  assign {a3_o_3, a2_o_3, a1_o_3} = a_q[3];
  assign {a3_o_4, a2_o_4, a1_o_4} = a_q[4];
  assign {a3_o_5, a2_o_5, a1_o_5} = a_q[5];
  assign {b3_o_0, b2_o_0, b1_o_0} = b_q[0];
  assign {b3_o_1, b2_o_1, b1_o_1} = b_q[1];
  assign {b3_o_2, b2_o_2, b1_o_2} = b_q[2];
  assign {b3_o_3, b2_o_3, b1_o_3} = b_q[3];
  assign {b3_o_4, b2_o_4, b1_o_4} = b_q[4];
  assign {b3_o_5, b2_o_5, b1_o_5} = b_q[5];
endmodule

// File: tb/tb_dtw_diag_feeder.sv
// tb_dtw_diag_feeder: directed checks of load, round issue, stall, drain and async reset of the feeder.
module tb_dtw_diag_feeder;
  logic clk = 1'b0, rst = 1'b0;
  logic wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, adv_i = 1'b0, finish_i = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [29:0] wr_data = '0;
  logic clr_o, valid, busy, done;
  logic [5:0] data_number, lg;
  logic [9:0] a1_o_0, a2_o_0, a3_o_0, b1_o_0, b2_o_0, b3_o_0;
  logic [9:0] a1_o_1, a2_o_1, a3_o_1, b1_o_1, b2_o_1, b3_o_1;
  logic [9:0] a1_o_2, a2_o_2, a3_o_2, b1_o_2, b2_o_2, b3_o_2;
  logic [9:0] a1_o_3, a2_o_3, a3_o_3, b1_o_3, b2_o_3, b3_o_3;
  logic [9:0] a1_o_4, a2_o_4, a3_o_4, b1_o_4, b2_o_4, b3_o_4;
  logic [9:0] a1_o_5, a2_o_5, a3_o_5, b1_o_5, b2_o_5, b3_o_5;
  logic legal_o_0, legal_o_1, legal_o_2, legal_o_3, legal_o_4, legal_o_5;
  int pass_cnt = 0, total_cnt = 0;
  dtw_diag_feeder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .adv_i(adv_i), .finish_i(finish_i), .clr_o(clr_o), .valid(valid),
    .data_number(data_number),
    .a1_o_0(a1_o_0), .a2_o_0(a2_o_0), .a3_o_0(a3_o_0), .b1_o_0(b1_o_0), .b2_o_0(b2_o_0), .b3_o_0(b3_o_0),
    .a1_o_1(a1_o_1), .a2_o_1(a2_o_1), .a3_o_1(a3_o_1), .b1_o_1(b1_o_1), .b2_o_1(b2_o_1), .b3_o_1(b3_o_1),
    .a1_o_2(a1_o_2), .a2_o_2(a2_o_2), .a3_o_2(a3_o_2), .b1_o_2(b1_o_2), .b2_o_2(b2_o_2), .b3_o_2(b3_o_2),
    .a1_o_3(a1_o_3), .a2_o_3(a2_o_3), .a3_o_3(a3_o_3), .b1_o_3(b1_o_3), .b2_o_3(b2_o_3), .b3_o_3(b3_o_3),
    .a1_o_4(a1_o_4), .a2_o_4(a2_o_4), .a3_o_4(a3_o_4), .b1_o_4(b1_o_4), .b2_o_4(b2_o_4), .b3_o_4(b3_o_4),
    .a1_o_5(a1_o_5), .a2_o_5(a2_o_5), .a3_o_5(a3_o_5), .b1_o_5(b1_o_5), .b2_o_5(b2_o_5), .b3_o_5(b3_o_5),
    .legal_o_0(legal_o_0), .legal_o_1(legal_o_1), .legal_o_2(legal_o_2),
    .legal_o_3(legal_o_3), .legal_o_4(legal_o_4), .legal_o_5(legal_o_5),
    .busy(busy), .done(done)
  );
  assign lg = {legal_o_5, legal_o_4, legal_o_3, legal_o_2, legal_o_1, legal_o_0};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic write(input logic sel, input logic [4:0] addr, input logic [29:0] data);
    @(negedge clk);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic advance(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      adv_i = 1'b1;
      @(negedge clk);
      adv_i = 1'b0;
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_num"}, 32'(data_number), 32'd63);
    check({tag, "_ctl"}, {28'd0, valid, clr_o, done, busy}, 32'd0);
    check({tag, "_legal"}, 32'(lg), 32'd0);
    check({tag, "_a0"}, 32'(a1_o_0), 32'd0);
    check({tag, "_b3"}, 32'(b1_o_3), 32'd0);
  endtask
  initial begin
    #22;
    check_reset("rst0");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      write(1'b0, 5'(k), {3{10'(k)}});
      write(1'b1, 5'(k), {3{10'(2 * k)}});
    end
    pulse_start();
    check("clr_hi", {30'd0, clr_o, busy}, 32'd3);
    @(negedge clk);
    check("clr_lo", 32'(clr_o), 32'd0);
    check("r0_num", {26'd0, valid, data_number}, {26'd0, 1'b1, 6'd0});
    check("r0_legal", 32'(lg), 32'b000100);
    check("r0_ab", {a1_o_2, b1_o_2}, 32'd0);
    for (int k = 0; k < 5; k++) @(negedge clk);
    check("hold_num", 32'(data_number), 32'd0);
    check("hold_legal", 32'(lg), 32'b000100);
    advance(1);
    check("r1_num", 32'(data_number), 32'd1);
    check("r1_legal", 32'(lg), 32'b001100);
    check("r1_l2", {a1_o_2, b1_o_2}, {10'd0, 10'd2});
    check("r1_l3", {a1_o_3, b1_o_3}, {10'd1, 10'd0});
    advance(1);
    check("r2_legal", 32'(lg), 32'b001110);
    check("r2_l1", {a1_o_1, b1_o_1}, {10'd0, 10'd4});
    advance(8);
    check("r10_num", 32'(data_number), 32'd10);
    check("r10_legal", 32'(lg), 32'b111111);
    check("r10_l0", {a1_o_0, b1_o_0}, {10'd3, 10'd14});
    check("r10_l5", {a3_o_5, b3_o_5}, {10'd8, 10'd4});
    #2 rst = 1'b0;
    #1 check_reset("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    pulse_start();
    check("clr2_hi", 32'(clr_o), 32'd1);
    @(negedge clk);
    check("r0b_num", {26'd0, valid, data_number}, {26'd0, 1'b1, 6'd0});
    check("r0b_legal", 32'(lg), 32'b000100);
    write(1'b0, 5'd19, {3{10'd500}});
    write(1'b1, 5'd19, {3{10'd501}});
    pulse_start();
    check("busy_start", {30'd0, clr_o, busy}, 32'd1);
    advance(1);
    check("r1b_l3", {a1_o_3, b1_o_3}, {10'd1, 10'd0});
    advance(37);
    check("r38_num", 32'(data_number), 32'd38);
    check("r38_legal", 32'(lg), 32'b000100);
    check("r38_a", {2'd0, a3_o_2, a2_o_2, a1_o_2}, {2'd0, {3{10'd19}}});
    check("r38_b", {2'd0, b3_o_2, b2_o_2, b1_o_2}, {2'd0, {3{10'd38}}});
    advance(1);
    check("r39_num", 32'(data_number), 32'd39);
    check("r39_legal", 32'(lg), 32'd0);
    check("r39_ab", {a1_o_2, b1_o_2}, 32'd0);
    advance(1);
    for (int k = 0; k < 3; k++) begin
      check("drain_wait", {26'd0, done, busy, valid, 3'd0}, {26'd0, 1'b0, 1'b1, 1'b1, 3'd0});
      check("drain_num", 32'(data_number), 32'd39);
      @(negedge clk);
    end
    finish_i = 1'b1;
    @(negedge clk);
    finish_i = 1'b0;
    check("done_hi", {29'd0, done, busy, valid}, 32'b100);
    check("done_num", 32'(data_number), 32'd63);
    @(negedge clk);
    check("done_lo", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
